// File: rtl/otter_cu_fsm.sv
//------------------------------------------------------------------------------
// otter_cu_fsm : multicycle control FSM for the OTTER core
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module otter_cu_fsm #(
  parameter int INSTRET_W = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 INTR,
  input  logic                 MIE,
  input  logic [6:0]           IR_OPCODE,
  input  logic [2:0]           IR_FUNCT,
  output logic                 PC_WRITE,
  output logic                 PC_RST,
  output logic                 REG_WRITE,
  output logic                 MEM_RDEN1,
  output logic                 MEM_RDEN2,
  output logic                 MEM_WE2,
  output logic                 CSR_WE,
  output logic                 INT_TAKEN,
  output logic                 MRET_EXEC,
  output logic [INSTRET_W-1:0] INSTRET
);

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_OP     = 7'b0110011;
  localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

  localparam logic [INSTRET_W-1:0] c_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [INSTRET_W-1:0]   instret_q;
  logic                   w_complete;
  logic                   w_is_load;

  assign w_is_load = (IR_OPCODE == c_OP_LOAD);

  // Loads retire at WB; every other instruction retires in EXEC.
  assign w_complete = ((state_q == ST_EXEC) && !w_is_load) || (state_q == ST_WB);

  always_comb begin
    state_d   = ST_INIT;
    PC_WRITE  = 1'b0;
    PC_RST    = 1'b0;
    REG_WRITE = 1'b0;
    MEM_RDEN1 = 1'b0;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    CSR_WE    = 1'b0;
    INT_TAKEN = 1'b0;
    MRET_EXEC = 1'b0;

    case (state_q)
      ST_INIT: begin
        PC_RST  = 1'b1;
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        MEM_RDEN1 = 1'b1;
        state_d   = ST_EXEC;
      end

      ST_EXEC: begin
        state_d = (INTR && MIE) ? ST_INTR : ST_FETCH;
        case (IR_OPCODE)
          c_OP_LOAD: begin
            MEM_RDEN2 = 1'b1;
            state_d   = ST_WB;
          end
          c_OP_STORE: begin
            MEM_WE2  = 1'b1;
            PC_WRITE = 1'b1;
          end
          c_OP_BRANCH: begin
            PC_WRITE = 1'b1;
          end
          c_OP_OP, c_OP_OPIMM, c_OP_LUI, c_OP_AUIPC, c_OP_JAL, c_OP_JALR: begin
            PC_WRITE  = 1'b1;
            REG_WRITE = 1'b1;
          end
          c_OP_SYSTEM: begin
            PC_WRITE = 1'b1;
            if (IR_FUNCT != 3'b000) begin
              REG_WRITE = 1'b1;
              CSR_WE    = 1'b1;
            end else begin
              MRET_EXEC = 1'b1;
            end
          end
          default: begin
            // Unknown opcodes are skipped but still retire.
            PC_WRITE = 1'b1;
          end
        endcase
      end

      ST_WB: begin
        REG_WRITE = 1'b1;
        PC_WRITE  = 1'b1;
        state_d   = (INTR && MIE) ? ST_INTR : ST_FETCH;
      end

      ST_INTR: begin
        INT_TAKEN = 1'b1;
        PC_WRITE  = 1'b1;
        state_d   = ST_FETCH;
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_INIT;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_complete) begin
        instret_q <= instret_q + c_ONE;
      end
    end
  end

  assign INSTRET = instret_q;

endmodule

`default_nettype wire
